// File: rtl/nf10_pkt_pattern_pkg.sv
// rtl/nf10_pkt_pattern_pkg.sv - test-frame pattern constants, error codes and checker state type
package nf10_pkt_pattern_pkg;

    localparam logic [63:0] HDR_WORD0 = 64'hEFBEFECAFECAFECA;
    localparam logic [63:0] HDR_WORD1 = 64'h00000008EFBEEFBE;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_DATA  = 3'd1,
        ERR_STRB  = 3'd2,
        ERR_SHORT = 3'd3,
        ERR_LONG  = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DRAIN
    } state_e;

    // Header bytes first, then each 64-bit payload word repeats its own word index.
    function automatic logic [7:0] exp_byte(input logic [31:0] offset);
        logic [31:0] word_idx;
        word_idx = (offset - 32'd16) >> 3;
        if (offset < 32'd8) begin
            exp_byte = HDR_WORD0[{offset[2:0], 3'b000} +: 8];
        end else if (offset < 32'd16) begin
            exp_byte = HDR_WORD1[{offset[2:0], 3'b000} +: 8];
        end else begin
            exp_byte = word_idx[7:0];
        end
    endfunction

endpackage

// File: rtl/nf10_lfsr16.sv
// rtl/nf10_lfsr16.sv - seeded 16-bit Fibonacci LFSR (taps 16,14,13,11)
module nf10_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/nf10_axis_pkt_checker.sv
// rtl/nf10_axis_pkt_checker.sv - AXI4-Stream sink that checks the standard test frame and counts errors
module nf10_axis_pkt_checker #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 64,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          C_PAYLOAD_WORDS      = 32,
    parameter logic [15:0] C_LFSR_SEED          = 16'hACE1
) (
    input  logic                              axi_aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              bp_enable,
    input  logic                              clear_stats,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       err_count,
    output logic                              err_flag,
    output logic [2:0]                        err_type,
    output logic                              busy
);
    import nf10_pkt_pattern_pkg::*;

    localparam int          BYTES     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int          FRAME_LEN = 16 + 8 * C_PAYLOAD_WORDS;
    localparam int          REM       = FRAME_LEN % BYTES;
    localparam logic [31:0] BYTES_U   = 32'(BYTES);
    localparam logic [31:0] LEN_U     = 32'(FRAME_LEN);

    state_e      state_q, state_d;
    logic [31:0] offset_q, offset_d;
    logic        tready_q, tready_d;
    logic        frame_bad_q, frame_bad_d;
    logic        stat_upd_q, stat_upd_d;
    logic        stat_bad_q, stat_bad_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic        err_flag_q, err_flag_d;
    err_code_e   err_type_q, err_type_d;

    logic [15:0]      lfsr_state;
    logic             beat_acc;
    logic             checking;
    logic             at_end;
    logic [BYTES-1:0] lane_bad;
    logic [BYTES-1:0] req_last;
    logic [BYTES-1:0] req_strb;
    logic [31:0]      strb_cnt;
    err_code_e        beat_err;
    logic             unused_ok;

    nf10_lfsr16 #(
        .SEED   (C_LFSR_SEED)
    ) u_bp_lfsr (
        .clk    (axi_aclk),
        .reset  (reset),
        .enable (1'b1),
        .state  (lfsr_state)
    );

    assign unused_ok = ^{s_axis_tuser, lfsr_state[15:1]};

    assign beat_acc = s_axis_tvalid & tready_q;
    assign checking = beat_acc & (state_q != ST_DRAIN);
    assign at_end   = (offset_q + BYTES_U) >= LEN_U;

    // offset_q is held at zero in IDLE, so lane offsets are valid for a frame-start beat too.
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic [7:0] exp_b;
        assign exp_b       = exp_byte(offset_q + 32'(i));
        assign lane_bad[i] = s_axis_tstrb[i] & (s_axis_tdata[8*i +: 8] != exp_b);
        assign req_last[i] = (REM == 0) || (i < REM);
    end

    always_comb begin
        strb_cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            strb_cnt = strb_cnt + 32'(s_axis_tstrb[i]);
        end
    end

    assign req_strb = at_end ? req_last : {BYTES{1'b1}};

    always_comb begin
        beat_err = ERR_NONE;
        if (s_axis_tstrb != req_strb) begin
            beat_err = ERR_STRB;
        end else if (|lane_bad) begin
            beat_err = ERR_DATA;
        end else if (s_axis_tlast && ((offset_q + strb_cnt) < LEN_U)) begin
            beat_err = ERR_SHORT;
        end else if (!s_axis_tlast && at_end) begin
            beat_err = ERR_LONG;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any beat reaching the frame end without tlast drains, whichever error got reported.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        if (beat_acc) begin
            case (state_q)
                ST_IDLE, ST_PKT: begin
                    if (s_axis_tlast) begin
                        state_d  = ST_IDLE;
                        offset_d = '0;
                    end else if (at_end) begin
                        state_d  = ST_DRAIN;
                        offset_d = '0;
                    end else begin
                        state_d  = ST_PKT;
                        offset_d = offset_q + BYTES_U;
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    offset_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        tready_d    = ~bp_enable | lfsr_state[0];
        frame_bad_d = frame_bad_q;
        if (checking) begin
            frame_bad_d = ((state_q == ST_IDLE) ? 1'b0 : frame_bad_q) | (beat_err != ERR_NONE);
        end
        stat_upd_d = beat_acc & s_axis_tlast;
        stat_bad_d = frame_bad_d;

        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        err_flag_d  = err_flag_q;
        err_type_d  = err_type_q;
        if (clear_stats) begin
            pkt_count_d = '0;
            err_count_d = '0;
            err_flag_d  = 1'b0;
            err_type_d  = ERR_NONE;
        end else begin
            if (stat_upd_q) begin
                if (pkt_count_q != 32'hFFFF_FFFF) begin
                    pkt_count_d = pkt_count_q + 32'd1;
                end
                if (stat_bad_q && (err_count_q != 32'hFFFF_FFFF)) begin
                    err_count_d = err_count_q + 32'd1;
                end
            end
            if (!err_flag_q && checking && (beat_err != ERR_NONE)) begin
                err_flag_d = 1'b1;
                err_type_d = beat_err;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            offset_q    <= '0;
            tready_q    <= 1'b0;
            frame_bad_q <= 1'b0;
            stat_upd_q  <= 1'b0;
            stat_bad_q  <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            err_type_q  <= ERR_NONE;
        end else begin
            offset_q    <= offset_d;
            tready_q    <= tready_d;
            frame_bad_q <= frame_bad_d;
            stat_upd_q  <= stat_upd_d;
            stat_bad_q  <= stat_bad_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
            err_type_q  <= err_type_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign pkt_count     = pkt_count_q;
    assign err_count     = err_count_q;
    assign err_flag      = err_flag_q;
    assign err_type      = err_type_q;

endmodule

// File: tb/tb_nf10_axis_pkt_checker.sv
// tb/tb_nf10_axis_pkt_checker.sv - scoreboard bench for nf10_axis_pkt_checker at 64- and 256-bit widths
module tb_nf10_axis_pkt_checker;

    localparam int FRAME_LEN = 16 + 8 * 32;
    localparam logic [7:0] HDR [16] = '{8'hCA, 8'hFE, 8'hCA, 8'hFE, 8'hCA, 8'hFE, 8'hBE, 8'hEF,
                                        8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'h08, 8'h00, 8'h00, 8'h00};

    typedef struct {
        bit         bad;
        logic [2:0] typ;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic bp_enable;
    logic clear_stats;
    logic [127:0] tuser = '0;

    logic [63:0]  d64;
    logic [7:0]   s64;
    logic         v64, l64, r64, flag64, busy64;
    logic [31:0]  pkt64, err64;
    logic [2:0]   type64;

    logic [255:0] d256;
    logic [31:0]  s256;
    logic         v256, l256, r256, flag256, busy256;
    logic [31:0]  pkt256, err256;
    logic [2:0]   type256;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q64[$];
    exp_t q256[$];
    exp_t e64, e256;
    logic [31:0] prev_pkt64 = '0, prev_err64 = '0, prev_pkt256 = '0, prev_err256 = '0;
    bit bp_meas = 1'b0;
    int bp_total = 0;
    int bp_low   = 0;

    always #5 clk = ~clk;

    nf10_axis_pkt_checker #(.C_S_AXIS_DATA_WIDTH(64)) dut64 (
        .axi_aclk(clk), .reset(reset),
        .s_axis_tdata(d64), .s_axis_tstrb(s64), .s_axis_tuser(tuser),
        .s_axis_tvalid(v64), .s_axis_tlast(l64), .s_axis_tready(r64),
        .bp_enable(bp_enable), .clear_stats(clear_stats),
        .pkt_count(pkt64), .err_count(err64), .err_flag(flag64), .err_type(type64), .busy(busy64)
    );

    nf10_axis_pkt_checker #(.C_S_AXIS_DATA_WIDTH(256)) dut256 (
        .axi_aclk(clk), .reset(reset),
        .s_axis_tdata(d256), .s_axis_tstrb(s256), .s_axis_tuser(tuser),
        .s_axis_tvalid(v256), .s_axis_tlast(l256), .s_axis_tready(r256),
        .bp_enable(1'b0), .clear_stats(clear_stats),
        .pkt_count(pkt256), .err_count(err256), .err_flag(flag256), .err_type(type256), .busy(busy256)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] golden(input int o);
        if (o < 16) return HDR[o];
        return 8'((o - 16) / 8);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input bit wide);
        int n = 0;
        while (((wide ? r256 : r64) == 1'b0) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("tready_wait", 32'(wide ? r256 : r64), 32'd1);
    endtask

    // Drives beats first..min(stop_at,last_at); tlast only on last_at.
    task automatic send_frame(input bit wide, input int first, input int last_at, input int stop_at,
                              input int bad_beat, input int bad_byte,
                              input bit ovr, input logic [31:0] ovr_strb,
                              input bit push, input bit exp_bad, input logic [2:0] exp_type);
        int lanes;
        int nat;
        logic [255:0] d;
        logic [31:0] s;
        exp_t e;
        lanes = wide ? 32 : 8;
        nat = (FRAME_LEN + lanes - 1) / lanes;
        if (push) begin
            e.bad = exp_bad;
            e.typ = exp_type;
            if (wide) q256.push_back(e);
            else q64.push_back(e);
        end
        for (int b = first; (b <= stop_at) && (b <= last_at); b++) begin
            d = '0;
            s = '0;
            for (int i = 0; i < lanes; i++) begin
                int o;
                o = b * lanes + i;
                d[8*i +: 8] = ((b == bad_beat) && (i == bad_byte)) ? 8'h55 : golden(o);
                s[i] = (o < FRAME_LEN) || (b >= nat);
            end
            if (ovr && (b == last_at)) s = ovr_strb;
            if (wide) begin
                d256 = d; s256 = s; v256 = 1'b1; l256 = (b == last_at);
            end else begin
                d64 = d[63:0]; s64 = s[7:0]; v64 = 1'b1; l64 = (b == last_at);
            end
            wait_ready(wide);
            @(negedge clk);
        end
        v64 = 1'b0; l64 = 1'b0; v256 = 1'b0; l256 = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (pkt64 == prev_pkt64 + 32'd1) begin
            if (q64.size() == 0) begin
                check("sb64_unexpected_frame", pkt64, prev_pkt64);
            end else begin
                e64 = q64.pop_front();
                check("sb64_err_inc", err64 - prev_err64, 32'(e64.bad));
                if (e64.bad) check("sb64_err_type", 32'(type64), 32'(e64.typ));
            end
        end
        prev_pkt64 = pkt64;
        prev_err64 = err64;
    end

    always @(negedge clk) begin
        if (pkt256 == prev_pkt256 + 32'd1) begin
            if (q256.size() == 0) begin
                check("sb256_unexpected_frame", pkt256, prev_pkt256);
            end else begin
                e256 = q256.pop_front();
                check("sb256_err_inc", err256 - prev_err256, 32'(e256.bad));
                if (e256.bad) check("sb256_err_type", 32'(type256), 32'(e256.typ));
            end
        end
        prev_pkt256 = pkt256;
        prev_err256 = err256;
    end

    always @(negedge clk) begin
        if (bp_meas) begin
            bp_total++;
            if (!r64) bp_low++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; bp_enable = 1'b0; clear_stats = 1'b0;
        d64 = '0; s64 = '0; v64 = 1'b0; l64 = 1'b0;
        d256 = '0; s256 = '0; v256 = 1'b0; l256 = 1'b0;
        idle(3);
        check("rst_tready64", 32'(r64), 32'd0);
        check("rst_tready256", 32'(r256), 32'd0);
        check("rst_pkt64", pkt64, 32'd0);
        check("rst_err64", err64, 32'd0);
        check("rst_flag64", 32'(flag64), 32'd0);
        check("rst_type64", 32'(type64), 32'd0);
        check("rst_busy64", 32'(busy64), 32'd0);
        reset = 1'b0;
        idle(1);

        // clean 64-bit frame
        send_frame(0, 0, 33, 33, -1, -1, 0, '0, 1, 0, 3'd0);
        idle(2);
        check("clean64_pkt", pkt64, 32'd1);
        check("clean64_err", err64, 32'd0);
        check("clean64_flag", 32'(flag64), 32'd0);
        check("clean64_busy", 32'(busy64), 32'd0);

        // 256-bit: partial final strobe passes, full final strobe is a strobe error
        send_frame(1, 0, 8, 8, -1, -1, 0, '0, 1, 0, 3'd0);
        idle(2);
        check("clean256_pkt", pkt256, 32'd1);
        check("clean256_flag", 32'(flag256), 32'd0);
        send_frame(1, 0, 8, 8, -1, -1, 1, 32'hFFFF_FFFF, 1, 1, 3'd2);
        idle(2);
        check("strb256_err", err256, 32'd1);
        check("strb256_type", 32'(type256), 32'd2);

        // data corruption in payload word 5, then a clean frame
        pulse_clear();
        send_frame(0, 0, 33, 33, 7, 3, 0, '0, 1, 1, 3'd1);
        send_frame(0, 0, 33, 33, -1, -1, 0, '0, 1, 0, 3'd0);
        idle(2);
        check("data_pkt", pkt64, 32'd2);
        check("data_err", err64, 32'd1);
        check("data_type", 32'(type64), 32'd1);

        // short frame
        pulse_clear();
        send_frame(0, 0, 19, 19, -1, -1, 0, '0, 1, 1, 3'd3);
        idle(2);
        check("short_type", 32'(type64), 32'd3);

        // long frame: tlast withheld until beat 40
        pulse_clear();
        send_frame(0, 0, 40, 39, -1, -1, 0, '0, 1, 1, 3'd4);
        check("long_busy_mid", 32'(busy64), 32'd1);
        check("long_type", 32'(type64), 32'd4);
        send_frame(0, 40, 40, 40, -1, -1, 0, '0, 0, 0, 3'd0);
        idle(1);
        check("long_busy_after", 32'(busy64), 32'd0);
        send_frame(0, 0, 33, 33, -1, -1, 0, '0, 1, 0, 3'd0);
        idle(2);
        check("long_pkt", pkt64, 32'd2);
        check("long_err", err64, 32'd1);

        // clear coincident with the stats update drops that update
        pulse_clear();
        send_frame(0, 0, 33, 33, -1, -1, 0, '0, 0, 0, 3'd0);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        idle(2);
        check("clr_pkt", pkt64, 32'd0);
        check("clr_err", err64, 32'd0);

        // reset mid-frame at beat 10, resume the stale tail, then a clean frame
        send_frame(0, 0, 33, 9, -1, -1, 0, '0, 0, 0, 3'd0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        send_frame(0, 10, 33, 33, -1, -1, 0, '0, 1, 1, 3'd1);
        send_frame(0, 0, 33, 33, -1, -1, 0, '0, 1, 0, 3'd0);
        idle(2);
        check("rstmid_pkt", pkt64, 32'd2);
        check("rstmid_err", err64, 32'd1);

        // random backpressure, back-to-back frames
        pulse_clear();
        bp_enable = 1'b1;
        bp_meas = 1'b1;
        for (int f = 0; f < 200; f++) begin
            send_frame(0, 0, 33, 33, -1, -1, 0, '0, 1, 0, 3'd0);
        end
        bp_meas = 1'b0;
        bp_enable = 1'b0;
        idle(3);
        check("bp_pkt", pkt64, 32'd200);
        check("bp_err", err64, 32'd0);
        check("bp_low_quarter", 32'(bp_low * 4 >= bp_total), 32'd1);

        check("sb64_drained", 32'(q64.size()), 32'd0);
        check("sb256_drained", 32'(q256.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
